action_executor: RTL and testbench

- Pipeline stage directly downstream of the flow matcher.
- Consumes the matcher's `ready`/`is_match`/flow-value result and writes the value bytes into the packet header at a runtime-configured field (header id + offset + length).
- On a miss, either passes the header through unchanged or flags the packet for drop, per configuration.
- Produces the modified header and a drop flag for the deparser/output stage.

---
 rtl/action_executor_pkg.sv | 28 ++
 rtl/action_executor.sv | 154 +++++++++++++++
 tb/tb_action_executor.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/action_executor_pkg.sv
// Shared types and bus geometry for the action executor and the control-plane loader.
package action_executor_pkg;

  localparam int unsigned BYTE_BUS    = 8;
  localparam int unsigned MAX_VAL_LEN = 16;
  localparam int unsigned HDR_MAX_LEN = 64;
  localparam int unsigned DATA_BUS    = 16;
  localparam int unsigned NUM_HEADERS = 16;

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } exec_state_e;

  typedef struct packed {
    logic [3:0] hdr_id;
    logic [5:0] off;
    logic [5:0] len;
    logic       miss_drop;
  } act_cfg_t;

  function automatic logic [5:0] clamp_len(input logic [5:0] len, input int unsigned max_len);
    if (32'(len) > max_len) return 6'(max_len);
    return len;
  endfunction

endpackage

// File: rtl/action_executor.sv
// Writes matcher value bytes into a configured header field, one byte per cycle.
// Optional hit/miss statistics outputs under ACTION_EXECUTOR_STATS_EN.
module action_executor
  import action_executor_pkg::*;
#(
  parameter int unsigned ACT_MAX_LEN = MAX_VAL_LEN
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start_i,
  input  logic                                     is_match_i,
  input  logic [MAX_VAL_LEN-1:0][BYTE_BUS-1:0]     flow_val_i,
  input  logic [HDR_MAX_LEN-1:0][BYTE_BUS-1:0]     pkt_hdr_i,
  input  logic [NUM_HEADERS-1:0][DATA_BUS-1:0]     parsed_hdrs_i,
  input  logic                                     mod_start_i,
  input  logic [3:0]                               mod_act_hdr_id_i,
  input  logic [5:0]                               mod_act_off_i,
  input  logic [5:0]                               mod_act_len_i,
  input  logic                                     mod_miss_drop_i,
  output logic                                     ready_o,
  output logic                                     drop_o,
  output logic [HDR_MAX_LEN-1:0][BYTE_BUS-1:0]     pkt_hdr_o
`ifdef ACTION_EXECUTOR_STATS_EN
  ,
  output logic [31:0]                              hit_cnt_o,
  output logic [31:0]                              miss_cnt_o
`endif
);

  localparam int unsigned AW = DATA_BUS + 1;

  exec_state_e                              state_q, state_d;
  act_cfg_t                                 cfg_q, cfg_d;
  logic                                     match_q, match_d;
  logic [MAX_VAL_LEN-1:0][BYTE_BUS-1:0]     val_q, val_d;
  logic [DATA_BUS-1:0]                      base_q, base_d;
  logic [5:0]                               cnt_q, cnt_d;
  logic                                     ready_q, ready_d;
  logic                                     drop_q, drop_d;
  logic [HDR_MAX_LEN-1:0][BYTE_BUS-1:0]     hdr_q, hdr_d;

  logic [AW-1:0]                            wr_addr;
  logic [BYTE_BUS-1:0]                      wr_byte;

  // One extra bit keeps base+cnt from wrapping back into the header range.
  assign wr_addr = {1'b0, base_q} + AW'(cnt_q);

  always_ff @(posedge clk) begin
    if (rst) state_q <= FREE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FREE:    if (!mod_start_i && start_i) state_d = WRITE;
      WRITE:   if (!match_q || cnt_q == cfg_q.len) state_d = DONE;
      DONE:    if (!start_i) state_d = FREE;
      default: state_d = FREE;
    endcase
  end

  always_comb begin
    cfg_d   = cfg_q;
    match_d = match_q;
    val_d   = val_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    drop_d  = drop_q;
    hdr_d   = hdr_q;
    wr_byte = '0;
    for (int unsigned i = 0; i < MAX_VAL_LEN; i++) begin
      if (6'(i) == cnt_q) wr_byte = val_q[i];
    end
    case (state_q)
      FREE: begin
        if (mod_start_i) begin
          cfg_d.hdr_id    = mod_act_hdr_id_i;
          cfg_d.off       = mod_act_off_i;
          cfg_d.len       = clamp_len(mod_act_len_i, ACT_MAX_LEN);
          cfg_d.miss_drop = mod_miss_drop_i;
        end else if (start_i) begin
          ready_d = 1'b0;
          drop_d  = 1'b0;
          hdr_d   = pkt_hdr_i;
          match_d = is_match_i;
          val_d   = flow_val_i;
          base_d  = parsed_hdrs_i[cfg_q.hdr_id] + DATA_BUS'(cfg_q.off);
          cnt_d   = '0;
        end
      end
      WRITE: begin
        if (!match_q) begin
          drop_d  = cfg_q.miss_drop;
          ready_d = 1'b1;
        end else if (cnt_q == cfg_q.len) begin
          ready_d = 1'b1;
        end else begin
          for (int unsigned i = 0; i < HDR_MAX_LEN; i++) begin
            if (wr_addr == AW'(i)) hdr_d[i] = wr_byte;
          end
          cnt_d = cnt_q + 6'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q   <= '0;
      match_q <= 1'b0;
      val_q   <= '0;
      base_q  <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      drop_q  <= 1'b0;
      hdr_q   <= '0;
    end else begin
      cfg_q   <= cfg_d;
      match_q <= match_d;
      val_q   <= val_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      drop_q  <= drop_d;
      hdr_q   <= hdr_d;
    end
  end

  assign ready_o   = ready_q;
  assign drop_o    = drop_q;
  assign pkt_hdr_o = hdr_q;

`ifdef ACTION_EXECUTOR_STATS_EN
  logic [31:0] hit_q, miss_q;

  // cnt is still zero only on the first WRITE cycle of each packet.
  always_ff @(posedge clk) begin
    if (rst || (state_q == FREE && mod_start_i)) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (state_q == WRITE && cnt_q == '0) begin
      if (match_q && hit_q != '1)   hit_q  <= hit_q + 32'd1;
      if (!match_q && miss_q != '1) miss_q <= miss_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_q;
  assign miss_cnt_o = miss_q;
`endif

endmodule

// File: tb/tb_action_executor.sv
// Scoreboard bench for action_executor: directed cases plus randomized packets and configs.
module tb_action_executor;
  import action_executor_pkg::*;

  localparam int unsigned ACT = MAX_VAL_LEN;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_i = 1'b0;
  logic is_match_i = 1'b0;
  logic [MAX_VAL_LEN-1:0][7:0]  flow_val_i = '0;
  logic [HDR_MAX_LEN-1:0][7:0]  pkt_hdr_i = '0;
  logic [NUM_HEADERS-1:0][15:0] parsed_hdrs_i = '0;
  logic mod_start_i = 1'b0;
  logic [3:0] mod_act_hdr_id_i = '0;
  logic [5:0] mod_act_off_i = '0;
  logic [5:0] mod_act_len_i = '0;
  logic mod_miss_drop_i = 1'b0;
  logic ready_o, drop_o;
  logic [HDR_MAX_LEN-1:0][7:0] pkt_hdr_o;
`ifdef ACTION_EXECUTOR_STATS_EN
  logic [31:0] hit_cnt_o, miss_cnt_o;
  int st_hit = 0, st_miss = 0;
`endif

  action_executor #(.ACT_MAX_LEN(ACT)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .is_match_i(is_match_i),
    .flow_val_i(flow_val_i), .pkt_hdr_i(pkt_hdr_i), .parsed_hdrs_i(parsed_hdrs_i),
    .mod_start_i(mod_start_i), .mod_act_hdr_id_i(mod_act_hdr_id_i),
    .mod_act_off_i(mod_act_off_i), .mod_act_len_i(mod_act_len_i),
    .mod_miss_drop_i(mod_miss_drop_i), .ready_o(ready_o), .drop_o(drop_o),
    .pkt_hdr_o(pkt_hdr_o)
`ifdef ACTION_EXECUTOR_STATS_EN
    , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [HDR_MAX_LEN-1:0][7:0] hdr;
    logic drop;
    int due;
    string name;
  } exp_t;
  exp_t sb[$];

  // Reference configuration as the control plane believes it to be.
  int m_id = 0, m_off = 0, m_len = 0;
  logic m_md = 1'b0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [HDR_MAX_LEN-1:0][7:0] model_hdr(
      input logic [HDR_MAX_LEN-1:0][7:0] h, input logic m,
      input logic [MAX_VAL_LEN-1:0][7:0] v, input int base, input int len);
    logic [HDR_MAX_LEN-1:0][7:0] r;
    r = h;
    if (m) for (int i = 0; i < len; i++) if (base + i < int'(HDR_MAX_LEN)) r[base + i] = v[i];
    return r;
  endfunction

  task automatic model_cfg(input int id, input int off, input int len, input logic md);
    m_id = id; m_off = off; m_md = md;
    m_len = (len > int'(ACT)) ? int'(ACT) : len;
`ifdef ACTION_EXECUTOR_STATS_EN
    st_hit = 0; st_miss = 0;
`endif
  endtask

  task automatic set_cfg(input int id, input int off, input int len, input logic md);
    @(negedge clk);
    mod_act_hdr_id_i = 4'(id); mod_act_off_i = 6'(off);
    mod_act_len_i = 6'(len); mod_miss_drop_i = md; mod_start_i = 1'b1;
    model_cfg(id, off, len, md);
    @(negedge clk);
    mod_start_i = 1'b0;
  endtask

  task automatic finish_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  // One request; with_cfg presents a config write in the same cycle as start_i.
  task automatic run_pkt(input string name, input logic m, input logic [MAX_VAL_LEN-1:0][7:0] v,
                         input logic [HDR_MAX_LEN-1:0][7:0] h, input bit with_cfg,
                         input int id, input int off, input int len, input logic md);
    exp_t e;
    int c0, base, lat;
    bit seen;
    @(negedge clk);
    is_match_i = m; flow_val_i = v; pkt_hdr_i = h; start_i = 1'b1;
    c0 = cyc;
    if (with_cfg) begin
      mod_act_hdr_id_i = 4'(id); mod_act_off_i = 6'(off);
      mod_act_len_i = 6'(len); mod_miss_drop_i = md; mod_start_i = 1'b1;
      model_cfg(id, off, len, md);
    end
    base = int'(parsed_hdrs_i[m_id]) + m_off;
    lat = m ? m_len + 2 : 2;
    e.hdr = model_hdr(h, m, v, base, m_len);
    e.drop = !m && m_md;
    e.due = c0 + (with_cfg ? 1 : 0) + lat;
    e.name = name;
    sb.push_back(e);
`ifdef ACTION_EXECUTOR_STATS_EN
    if (m) st_hit++; else st_miss++;
`endif
    if (with_cfg) begin
      @(negedge clk);
      mod_start_i = 1'b0;
    end
    @(negedge clk);
    // Inputs are only sampled on the accepting edge; scramble them afterwards.
    is_match_i = 1'($urandom); pkt_hdr_i = {16{$urandom}};
    flow_val_i = {4{$urandom}}; parsed_hdrs_i = {8{$urandom}};
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      if (ready_o) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL %s_timeout: ready_o never rose, expected at cycle %0d", name, e.due);
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "ready_o timeout");
    end
    start_i = 1'b0;
  endtask

  // Monitor: pops one expectation on every rising ready_o.
  initial begin
    logic prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && ready_o && !prev) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_ready: got ready_o=1 expected no pending request");
        end else begin
          e = sb.pop_front();
          chk({e.name, "_hdr"}, 512'(pkt_hdr_o), 512'(e.hdr));
          chk({e.name, "_drop"}, 512'(drop_o), 512'(e.drop));
          chk({e.name, "_lat"}, 512'(cyc), 512'(e.due));
        end
      end
      prev = rst ? 1'b0 : ready_o;
    end
  end

  initial begin
    logic [MAX_VAL_LEN-1:0][7:0] v;
    logic [HDR_MAX_LEN-1:0][7:0] h;
    repeat (3) @(negedge clk);
    chk("reset_ready", 512'(ready_o), 512'(0));
    chk("reset_drop", 512'(drop_o), 512'(0));
    chk("reset_hdr", 512'(pkt_hdr_o), 512'(0));
    rst = 1'b0;

    // Basic hit: base = 14 + 2 = 16.
    parsed_hdrs_i = '0; parsed_hdrs_i[1] = 16'd14;
    set_cfg(1, 2, 4, 1'b0);
    v = '0; v[0] = 8'hAA; v[1] = 8'hBB; v[2] = 8'hCC; v[3] = 8'hDD;
    h = {16{$urandom}};
    run_pkt("hit_basic", 1'b1, v, h, 0, 0, 0, 0, 0);

    set_cfg(1, 2, 4, 1'b1);
    run_pkt("miss_drop", 1'b0, {4{$urandom}}, {16{$urandom}}, 0, 0, 0, 0, 0);
    set_cfg(1, 2, 4, 1'b0);
    run_pkt("miss_fwd", 1'b0, {4{$urandom}}, {16{$urandom}}, 0, 0, 0, 0, 0);

    // Field starts two bytes before the end of the header.
    parsed_hdrs_i[1] = 16'd60;
    run_pkt("oob", 1'b1, {4{$urandom}}, {16{$urandom}}, 0, 0, 0, 0, 0);

    // Same-cycle config write with an oversized length.
    parsed_hdrs_i[3] = 16'd5;
    run_pkt("cfg_clamp", 1'b1, {4{$urandom}}, {16{$urandom}}, 1, 3, 3, 63, 1'b0);

    // Reset in the middle of a 4-byte write.
    parsed_hdrs_i[1] = 16'd14;
    set_cfg(1, 2, 4, 1'b0);
    @(negedge clk);
    is_match_i = 1'b1; flow_val_i = {4{$urandom}}; pkt_hdr_i = {16{$urandom}}; start_i = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1; start_i = 1'b0;
    @(negedge clk);
    chk("midrst_ready", 512'(ready_o), 512'(0));
    chk("midrst_drop", 512'(drop_o), 512'(0));
    chk("midrst_hdr", 512'(pkt_hdr_o), 512'(0));
    rst = 1'b0;
    model_cfg(0, 0, 0, 1'b0);
    parsed_hdrs_i[0] = 16'd3;
    run_pkt("post_rst", 1'b1, {4{$urandom}}, {16{$urandom}}, 0, 0, 0, 0, 0);

`ifdef ACTION_EXECUTOR_STATS_EN
    set_cfg(0, 1, 2, 1'b0);
    for (int i = 0; i < 5; i++)
      run_pkt("stats_pkt", (i < 3), {4{$urandom}}, {16{$urandom}}, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("stats_hit", 512'(hit_cnt_o), 512'(st_hit));
    chk("stats_miss", 512'(miss_cnt_o), 512'(st_miss));
    set_cfg(0, 1, 2, 1'b0);
    chk("stats_clr_hit", 512'(hit_cnt_o), 512'(0));
    chk("stats_clr_miss", 512'(miss_cnt_o), 512'(0));
`endif

    for (int i = 0; i < 30; i++) begin
      int sel;
      sel = int'($urandom_range(0, 2));
      for (int k = 0; k < int'(NUM_HEADERS); k++) parsed_hdrs_i[k] = 16'($urandom_range(0, 70));
      if (sel == 1)
        set_cfg(int'($urandom_range(0, 15)), int'($urandom_range(0, 63)),
                int'($urandom_range(0, 63)), 1'($urandom));
      run_pkt("rand", 1'($urandom), {4{$urandom}}, {16{$urandom}}, (sel == 2),
              int'($urandom_range(0, 15)), int'($urandom_range(0, 63)),
              int'($urandom_range(0, 63)), 1'($urandom));
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", 512'(sb.size()), 512'(0));
    finish_run();
  end

endmodule
